leds_rgb_seq: RTL and testbench

- Per-line illumination sequencer for the scanner's RGB LED PWM driver.
- On each line trigger, steps through the enabled colours in fixed order R, G, B.
- For each colour it drives the PWM driver's START/END/RGB controls and a sensor shift-in pulse, then reports line completion.
- Sits between the line-timing/control register block and the LED PWM driver.

---
 rtl/leds_rgb_seq_if.sv | 39 +++
 rtl/leds_rgb_seq.sv | 200 ++++++++++++++++++++
 tb/tb_leds_rgb_seq.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/leds_rgb_seq_if.sv
// Control/status bundle between the line-timing register block and the RGB LED sequencer.
// LINE_PERIOD exists only when LEDS_SEQ_AUTOTRIG_EN is defined.
interface leds_rgb_seq_if #(
    parameter int CNT_W = 24
);
    logic             LINE_TRIG;
    logic             ABORT;
    logic [2:0]       COLOR_MASK;
    logic [CNT_W-1:0] EXP_R;
    logic [CNT_W-1:0] EXP_G;
    logic [CNT_W-1:0] EXP_B;
`ifdef LEDS_SEQ_AUTOTRIG_EN
    logic [31:0]      LINE_PERIOD;
`endif
    logic             LED_START;
    logic             LED_END;
    logic [2:0]       LED_RGB;
    logic             SENS_SI;
    logic             BUSY;
    logic             LINE_DONE;
    logic             TRIG_MISS;
    logic [15:0]      MISS_CNT;

    modport master (
        output LINE_TRIG, ABORT, COLOR_MASK, EXP_R, EXP_G, EXP_B,
`ifdef LEDS_SEQ_AUTOTRIG_EN
        output LINE_PERIOD,
`endif
        input  LED_START, LED_END, LED_RGB, SENS_SI, BUSY, LINE_DONE, TRIG_MISS, MISS_CNT
    );

    modport slave (
        input  LINE_TRIG, ABORT, COLOR_MASK, EXP_R, EXP_G, EXP_B,
`ifdef LEDS_SEQ_AUTOTRIG_EN
        input  LINE_PERIOD,
`endif
        output LED_START, LED_END, LED_RGB, SENS_SI, BUSY, LINE_DONE, TRIG_MISS, MISS_CNT
    );
endinterface

// File: rtl/leds_rgb_seq.sv
// Per-line R/G/B illumination sequencer driving the LED PWM driver and sensor shift-in.
// Optional internal period trigger: define LEDS_SEQ_AUTOTRIG_EN.
module leds_rgb_seq #(
    parameter int CNT_W = 24,
    parameter int GAP   = 4
) (
    input logic            CLK,
    input logic            RST,
    leds_rgb_seq_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP);

    // Highest-priority enabled colour (R over G over B) as a one-hot select.
    function automatic logic [2:0] first_color(input logic [2:0] m);
        logic [2:0] c;
        if (m[2]) begin
            c = 3'b100;
        end else if (m[1]) begin
            c = 3'b010;
        end else if (m[0]) begin
            c = 3'b001;
        end else begin
            c = 3'b000;
        end
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] exp_len(input logic [2:0] c,
                                                 input logic [CNT_W-1:0] r,
                                                 input logic [CNT_W-1:0] g,
                                                 input logic [CNT_W-1:0] b);
        logic [CNT_W-1:0] v;
        case (c)
            3'b100:  v = r;
            3'b010:  v = g;
            3'b001:  v = b;
            default: v = ONE_C;
        endcase
        return (v == {CNT_W{1'b0}}) ? ONE_C : v;
    endfunction

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       rem_r;
    logic [CNT_W-1:0] exp_r_r, exp_g_r, exp_b_r;
    logic             start_r, si_r, end_r, busy_r, done_r, miss_r;
    logic [2:0]       rgb_r;
    logic [15:0]      miss_cnt_r;

    logic             trig_s;
    logic [2:0]       idle_color_s, gap_color_s;
    logic [CNT_W-1:0] idle_len_s, gap_len_s;

`ifdef LEDS_SEQ_AUTOTRIG_EN
    logic [31:0] per_cnt_r;
    logic [31:0] per_len_r;
    logic        auto_pulse_s;

    assign auto_pulse_s = (per_len_r != 32'd0) && (per_cnt_r == (per_len_r - 32'd1));

    // Free-running line period counter; a new period is adopted only at wrap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            per_cnt_r <= 32'd0;
            per_len_r <= 32'd0;
        end else if (per_len_r == 32'd0 || auto_pulse_s) begin
            per_cnt_r <= 32'd0;
            per_len_r <= bus.LINE_PERIOD;
        end else begin
            per_cnt_r <= per_cnt_r + 32'd1;
        end
    end

    assign trig_s = bus.LINE_TRIG | auto_pulse_s;
`else
    assign trig_s = bus.LINE_TRIG;
`endif

    assign idle_color_s = first_color(bus.COLOR_MASK);
    assign idle_len_s   = exp_len(idle_color_s, bus.EXP_R, bus.EXP_G, bus.EXP_B);
    assign gap_color_s  = first_color(rem_r);
    assign gap_len_s    = exp_len(gap_color_s, exp_r_r, exp_g_r, exp_b_r);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            rem_r      <= 3'b000;
            exp_r_r    <= {CNT_W{1'b0}};
            exp_g_r    <= {CNT_W{1'b0}};
            exp_b_r    <= {CNT_W{1'b0}};
            start_r    <= 1'b0;
            si_r       <= 1'b0;
            end_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            miss_r     <= 1'b0;
            rgb_r      <= 3'b000;
            miss_cnt_r <= 16'd0;
        end else begin
            start_r <= 1'b0;
            si_r    <= 1'b0;
            end_r   <= 1'b0;
            done_r  <= 1'b0;
            miss_r  <= 1'b0;

            if (state_r != ST_IDLE && trig_s) begin
                miss_r <= 1'b1;
                if (miss_cnt_r != 16'hFFFF) begin
                    miss_cnt_r <= miss_cnt_r + 16'd1;
                end
            end

            if (state_r != ST_IDLE && bus.ABORT) begin
                // Only an interrupted exposure needs END to close the PWM cycle.
                state_r <= ST_IDLE;
                rgb_r   <= 3'b000;
                busy_r  <= 1'b0;
                end_r   <= (state_r == ST_ON);
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (trig_s && !bus.ABORT) begin
                            exp_r_r <= bus.EXP_R;
                            exp_g_r <= bus.EXP_G;
                            exp_b_r <= bus.EXP_B;
                            rem_r   <= bus.COLOR_MASK & ~idle_color_s;
                            busy_r  <= 1'b1;
                            if (idle_color_s != 3'b000) begin
                                state_r <= ST_ON;
                                rgb_r   <= idle_color_s;
                                start_r <= 1'b1;
                                si_r    <= 1'b1;
                                cnt_r   <= idle_len_s;
                            end else begin
                                state_r <= ST_DONE;
                                rgb_r   <= 3'b000;
                                done_r  <= 1'b1;
                            end
                        end
                    end
                    ST_ON: begin
                        if (cnt_r == ONE_C) begin
                            state_r <= ST_GAP;
                            end_r   <= 1'b1;
                            cnt_r   <= GAP_LOAD;
                        end else begin
                            cnt_r <= cnt_r - ONE_C;
                        end
                    end
                    ST_GAP: begin
                        if (cnt_r == ONE_C) begin
                            if (gap_color_s != 3'b000) begin
                                state_r <= ST_ON;
                                rgb_r   <= gap_color_s;
                                start_r <= 1'b1;
                                si_r    <= 1'b1;
                                cnt_r   <= gap_len_s;
                                rem_r   <= rem_r & ~gap_color_s;
                            end else begin
                                state_r <= ST_DONE;
                                rgb_r   <= 3'b000;
                                done_r  <= 1'b1;
                            end
                        end else begin
                            cnt_r <= cnt_r - ONE_C;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                        rgb_r   <= 3'b000;
                    end
                endcase
            end
        end
    end

    assign bus.LED_START = start_r;
    assign bus.SENS_SI   = si_r;
    assign bus.LED_END   = end_r;
    assign bus.LED_RGB   = rgb_r;
    assign bus.BUSY      = busy_r;
    assign bus.LINE_DONE = done_r;
    assign bus.TRIG_MISS = miss_r;
    assign bus.MISS_CNT  = miss_cnt_r;
endmodule

// File: tb/tb_leds_rgb_seq.sv
// Self-checking bench for leds_rgb_seq: directed and randomized lines against a timeline model.
module tb_leds_rgb_seq;
    localparam int CNT_W = 24;
    localparam int GAP_C = 4;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    leds_rgb_seq_if #(.CNT_W(CNT_W)) bus ();
    leds_rgb_seq #(.CNT_W(CNT_W), .GAP(GAP_C)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    int total = 0;
    int bad = 0;
    int miss_model = 0;

    // Expected per-cycle vector {start, si, end, rgb[2:0], busy, done, miss}, index = cycles after trigger.
    logic [8:0] exp_v [0:127];
    logic       on_v  [0:127];

    function automatic logic [8:0] obs();
        return {bus.LED_START, bus.SENS_SI, bus.LED_END, bus.LED_RGB,
                bus.BUSY, bus.LINE_DONE, bus.TRIG_MISS};
    endfunction

    task automatic chk9(input string tag, input logic [8:0] o, input logic [8:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] o, input logic [15:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic void count_miss();
        if (miss_model < 65535) miss_model++;
    endfunction

    // Timeline of a line: colours in R,G,B order, each ON for max(exp,1) then GAP_C off, then one DONE cycle.
    task automatic build_model(input logic [2:0] m, input int er, input int eg, input int eb,
                               output int done_k);
        int k;
        int e;
        int ev [3];
        logic [2:0] oh;
        ev[0] = er; ev[1] = eg; ev[2] = eb;
        for (int i = 0; i < 128; i++) begin
            exp_v[i] = 9'd0;
            on_v[i]  = 1'b0;
        end
        k = 1;
        for (int c = 0; c < 3; c++) begin
            if (m[2-c]) begin
                e  = (ev[c] == 0) ? 1 : ev[c];
                oh = 3'b100 >> c;
                exp_v[k][8] = 1'b1;
                exp_v[k][7] = 1'b1;
                for (int i = 0; i < e + GAP_C; i++) begin
                    exp_v[k+i][5:3] = oh;
                    exp_v[k+i][2]   = 1'b1;
                end
                for (int i = 0; i < e; i++) on_v[k+i] = 1'b1;
                exp_v[k+e][6] = 1'b1;
                k = k + e + GAP_C;
            end
        end
        exp_v[k][2] = 1'b1;
        exp_v[k][1] = 1'b1;
        done_k = k;
    endtask

    // Trigger in the current cycle; optionally retrigger at rt1/rt2 and abort at ab (cycle offsets, 0 = none).
    task automatic run_line(input logic [2:0] m, input int er, input int eg, input int eb,
                            input int rt1, input int rt2, input int ab);
        int done_k;
        int last;
        build_model(m, er, eg, eb, done_k);
        if (ab > 0) begin
            exp_v[ab+1] = {2'b00, on_v[ab], 6'b000000};
            last = ab + 1;
        end else begin
            last = done_k + 1;
        end
        if (rt1 > 0) begin exp_v[rt1+1][0] = 1'b1; count_miss(); end
        if (rt2 > 0) begin exp_v[rt2+1][0] = 1'b1; count_miss(); end
        bus.COLOR_MASK = m;
        bus.EXP_R = CNT_W'(er);
        bus.EXP_G = CNT_W'(eg);
        bus.EXP_B = CNT_W'(eb);
        bus.LINE_TRIG = 1'b1;
        bus.ABORT = 1'b0;
        for (int k = 1; k <= last; k++) begin
            @(negedge CLK);
            chk9($sformatf("line m=%b exp=%0d/%0d/%0d k=%0d", m, er, eg, eb, k), obs(), exp_v[k]);
            bus.LINE_TRIG  = (k == rt1) || (k == rt2);
            bus.ABORT      = (k == ab);
            bus.COLOR_MASK = 3'($urandom_range(0, 7));
            bus.EXP_R      = CNT_W'($urandom_range(0, 9));
            bus.EXP_G      = CNT_W'($urandom_range(0, 9));
            bus.EXP_B      = CNT_W'($urandom_range(0, 9));
        end
        bus.LINE_TRIG = 1'b0;
        bus.ABORT = 1'b0;
        chk16($sformatf("miss_cnt after m=%b", m), bus.MISS_CNT, 16'(miss_model));
    endtask

    initial begin
        RST = 1'b1;
        bus.LINE_TRIG = 1'b0;
        bus.ABORT = 1'b0;
        bus.COLOR_MASK = 3'b000;
        bus.EXP_R = '0;
        bus.EXP_G = '0;
        bus.EXP_B = '0;
`ifdef LEDS_SEQ_AUTOTRIG_EN
        bus.LINE_PERIOD = 32'd0;
`endif
        repeat (3) @(negedge CLK);
        chk9("reset outputs", obs(), 9'd0);
        chk16("reset miss_cnt", bus.MISS_CNT, 16'd0);
        RST = 1'b0;
        @(negedge CLK);

        run_line(3'b111, 3, 2, 1, 0, 0, 0);
        run_line(3'b010, 5, 0, 7, 0, 0, 0);
        run_line(3'b000, 2, 2, 2, 0, 0, 0);
        // Retrigger during R exposure and during the DONE cycle.
        run_line(3'b111, 3, 2, 1, 2, 19, 0);

        // Saturation of the miss counter.
        @(negedge CLK);
        force dut.miss_cnt_r = 16'hFFFF;
        @(negedge CLK);
        release dut.miss_cnt_r;
        miss_model = 65535;
        run_line(3'b100, 3, 0, 0, 2, 0, 0);

        // Abort during G exposure, then an immediate new line; abort during GAP.
        run_line(3'b111, 3, 2, 1, 0, 0, 9);
        run_line(3'b111, 2, 3, 1, 0, 0, 0);
        run_line(3'b110, 2, 2, 0, 0, 0, 4);

        // ABORT and LINE_TRIG together in IDLE: nothing starts, nothing counted.
        bus.ABORT = 1'b1;
        bus.LINE_TRIG = 1'b1;
        @(negedge CLK);
        bus.ABORT = 1'b0;
        bus.LINE_TRIG = 1'b0;
        chk9("abort+trig idle", obs(), 9'd0);
        chk16("abort+trig idle miss_cnt", bus.MISS_CNT, 16'(miss_model));

        // Reset in the middle of an exposure: no LED_END afterwards.
        bus.COLOR_MASK = 3'b111;
        bus.EXP_R = CNT_W'(3);
        bus.LINE_TRIG = 1'b1;
        @(negedge CLK);
        bus.LINE_TRIG = 1'b0;
        chk9("pre-reset start", obs(), 9'b110100100);
        RST = 1'b1;
        @(negedge CLK);
        chk9("mid-line reset", obs(), 9'd0);
        chk16("mid-line reset miss_cnt", bus.MISS_CNT, 16'd0);
        miss_model = 0;
        RST = 1'b0;
        @(negedge CLK);
        chk9("post-reset idle", obs(), 9'd0);

        // Randomized lines, sometimes with a retrigger in the first (always busy) cycle.
        for (int n = 0; n < 24; n++) begin
            run_line(3'($urandom_range(0, 7)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 1)), 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
